// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: default sizes, FSM encoding,
// bus source index map and small decode helpers.
package bus_arbiter_pkg;

    // Default number of valid bus source/destination indices
    localparam int NSRC_DEFAULT      = 24;
    // Default longest run of back-to-back grants to one locked requester
    localparam int MAX_BURST_DEFAULT = 4;
    // Width of one packed source/destination index field
    localparam int SEL_W             = 5;
    // Width of the one-hot bus control and load-enable words
    localparam int BUS_W             = 32;

    // Arbiter FSM: IDLE = nothing granted last cycle, GRANT = unlocked grant,
    // LOCKED = a burst owner holds the bus
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    // Bus source / destination index map
    localparam logic [4:0] SRC_R0     = 5'd0;
    localparam logic [4:0] SRC_R1     = 5'd1;
    localparam logic [4:0] SRC_R2     = 5'd2;
    localparam logic [4:0] SRC_R3     = 5'd3;
    localparam logic [4:0] SRC_R4     = 5'd4;
    localparam logic [4:0] SRC_R5     = 5'd5;
    localparam logic [4:0] SRC_R6     = 5'd6;
    localparam logic [4:0] SRC_R7     = 5'd7;
    localparam logic [4:0] SRC_R8     = 5'd8;
    localparam logic [4:0] SRC_R9     = 5'd9;
    localparam logic [4:0] SRC_R10    = 5'd10;
    localparam logic [4:0] SRC_R11    = 5'd11;
    localparam logic [4:0] SRC_R12    = 5'd12;
    localparam logic [4:0] SRC_R13    = 5'd13;
    localparam logic [4:0] SRC_R14    = 5'd14;
    localparam logic [4:0] SRC_R15    = 5'd15;
    localparam logic [4:0] SRC_HI     = 5'd16;
    localparam logic [4:0] SRC_LO     = 5'd17;
    localparam logic [4:0] SRC_ZHI    = 5'd18;
    localparam logic [4:0] SRC_ZLO    = 5'd19;
    localparam logic [4:0] SRC_PC     = 5'd20;
    localparam logic [4:0] SRC_MDR    = 5'd21;
    localparam logic [4:0] SRC_INPORT = 5'd22;
    localparam logic [4:0] SRC_CSIGN  = 5'd23;

    // Decode a 5-bit index into a 32-bit one-hot word
    function automatic logic [BUS_W-1:0] onehot32(input logic [SEL_W-1:0] idx);
        return {{(BUS_W-1){1'b0}}, 1'b1} << idx;
    endfunction

    // True when a 5-bit index addresses one of the first nsrc bus slots
    function automatic logic idx_in_range(input logic [SEL_W-1:0] idx, input int nsrc);
        return ({1'b0, idx} < 6'(nsrc));
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_pick.sv
// Round-robin priority picker: scans the request vector starting at the
// pointer position and returns the first requester found, one-hot and
// as an index. Purely combinational.
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    // Walk the requesters in priority order and keep only the first hit
    always_comb begin
        int idx;
        winner  = {NREQ{1'b0}};
        win_idx = {IW{1'b0}};
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (req[idx] && !any) begin
                winner[idx] = 1'b1;
                win_idx     = IW'(idx);
                any         = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Bus arbiter: picks one requester per cycle (round-robin with optional
// locked bursts), and drives the registered one-hot bus source select and
// destination load enable for the winner's transfer one cycle later.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int NSRC      = NSRC_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [SEL_W*NREQ-1:0] src_sel,
    input  logic [SEL_W*NREQ-1:0] dst_sel,
    output logic [NREQ-1:0]       gnt,
    output logic [BUS_W-1:0]      bus_ctrl,
    output logic [BUS_W-1:0]      ld_en,
    output logic                  busy,
    output logic [1:0]            owner,
    output logic                  err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    // FSM state and bookkeeping
    arb_state_t         state_r;
    logic [IW-1:0]      ptr_r;
    logic [IW-1:0]      lock_idx_r;
    logic [CW-1:0]      burst_cnt_r;

    // Registered outputs
    logic [NREQ-1:0]    gnt_r;
    logic [BUS_W-1:0]   bus_ctrl_r;
    logic [BUS_W-1:0]   ld_en_r;
    logic               busy_r;
    logic [1:0]         owner_r;
    logic               err_r;

    // Arbitration results for the current cycle
    logic [NREQ-1:0]    pick_onehot_s;
    logic [IW-1:0]      pick_idx_s;
    logic               pick_any_s;
    logic               keep_lock_s;
    logic               grant_any_s;
    logic [IW-1:0]      win_idx_s;
    logic [SEL_W-1:0]   src_s;
    logic [SEL_W-1:0]   dst_s;
    logic               valid_s;
    logic [IW-1:0]      ptr_next_s;

    rr_priority_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_r),
        .winner  (pick_onehot_s),
        .win_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    // Choose the winner: a live burst owner pre-empts round-robin arbitration
    always_comb begin
        keep_lock_s = (state_r == ST_LOCKED) && req[lock_idx_r] && lock[lock_idx_r]
                      && (burst_cnt_r < CW'(MAX_BURST));
        if (keep_lock_s) begin
            grant_any_s = 1'b1;
            win_idx_s   = lock_idx_r;
        end else begin
            grant_any_s = pick_any_s;
            win_idx_s   = pick_idx_s;
        end
        src_s   = src_sel[SEL_W*int'(win_idx_s) +: SEL_W];
        dst_s   = dst_sel[SEL_W*int'(win_idx_s) +: SEL_W];
        valid_s = idx_in_range(src_s, NSRC) && idx_in_range(dst_s, NSRC);
        if (win_idx_s == IW'(NREQ - 1)) begin
            ptr_next_s = {IW{1'b0}};
        end else begin
            ptr_next_s = win_idx_s + IW'(1);
        end
    end

    // FSM, priority pointer, burst counter and registered transfer outputs
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IW{1'b0}};
            lock_idx_r  <= {IW{1'b0}};
            burst_cnt_r <= {CW{1'b0}};
            gnt_r       <= {NREQ{1'b0}};
            bus_ctrl_r  <= {BUS_W{1'b0}};
            ld_en_r     <= {BUS_W{1'b0}};
            busy_r      <= 1'b0;
            owner_r     <= 2'd0;
            err_r       <= 1'b0;
        end else if (grant_any_s) begin
            gnt_r   <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
            owner_r <= 2'(win_idx_s);
            ptr_r   <= ptr_next_s;
            busy_r  <= valid_s;
            err_r   <= !valid_s;
            if (valid_s) begin
                bus_ctrl_r <= onehot32(src_s);
                ld_en_r    <= onehot32(dst_s);
            end else begin
                bus_ctrl_r <= {BUS_W{1'b0}};
                ld_en_r    <= {BUS_W{1'b0}};
            end
            case (1'b1)
                keep_lock_s: begin
                    state_r     <= ST_LOCKED;
                    burst_cnt_r <= burst_cnt_r + CW'(1);
                end
                lock[win_idx_s]: begin
                    state_r     <= ST_LOCKED;
                    lock_idx_r  <= win_idx_s;
                    burst_cnt_r <= CW'(1);
                end
                default: begin
                    state_r     <= ST_GRANT;
                    burst_cnt_r <= {CW{1'b0}};
                end
            endcase
        end else begin
            state_r     <= ST_IDLE;
            burst_cnt_r <= {CW{1'b0}};
            gnt_r       <= {NREQ{1'b0}};
            bus_ctrl_r  <= {BUS_W{1'b0}};
            ld_en_r     <= {BUS_W{1'b0}};
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end
    end

    assign gnt      = gnt_r;
    assign bus_ctrl = bus_ctrl_r;
    assign ld_en    = ld_en_r;
    assign busy     = busy_r;
    assign owner    = owner_r;
    assign err      = err_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random
// request/lock traffic compared against a behavioural model.
module tb_bus_arbiter;

    localparam int NREQ      = 4;
    localparam int NSRC      = 24;
    localparam int MAX_BURST = 4;

    logic        clock;
    logic        clear;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [19:0] src_sel;
    logic [19:0] dst_sel;
    logic [3:0]  gnt;
    logic [31:0] bus_ctrl;
    logic [31:0] ld_en;
    logic        busy;
    logic [1:0]  owner;
    logic        err;

    int tests_run;
    int tests_failed;

    // Reference model state
    int m_ptr;
    bit m_locked;
    int m_lowner;
    int m_cnt;
    int m_owner;

    // Expected outputs for the cycle after the current edge
    logic [3:0]  e_gnt;
    logic [31:0] e_bus;
    logic [31:0] e_ld;
    logic        e_busy;
    logic        e_err;

    bus_arbiter #(
        .NREQ      (NREQ),
        .NSRC      (NSRC),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .req      (req),
        .lock     (lock),
        .src_sel  (src_sel),
        .dst_sel  (dst_sel),
        .gnt      (gnt),
        .bus_ctrl (bus_ctrl),
        .ld_en    (ld_en),
        .busy     (busy),
        .owner    (owner),
        .err      (err)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Absolute run-time bound
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Compute what the arbiter must show after the coming edge
    task automatic model_edge();
        int win;
        bit cont;
        int s;
        int d;
        win  = -1;
        cont = 1'b0;
        e_gnt = 4'd0; e_bus = 32'd0; e_ld = 32'd0; e_busy = 1'b0; e_err = 1'b0;
        if (clear) begin
            m_ptr = 0; m_locked = 1'b0; m_lowner = 0; m_cnt = 0; m_owner = 0;
            return;
        end
        if (m_locked && req[m_lowner] && lock[m_lowner] && m_cnt < MAX_BURST) begin
            win  = m_lowner;
            cont = 1'b1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
        end
        if (win < 0) begin
            m_locked = 1'b0;
            return;
        end
        s = int'(src_sel[5*win +: 5]);
        d = int'(dst_sel[5*win +: 5]);
        e_gnt = 4'd0;
        e_gnt[win] = 1'b1;
        if (s < NSRC && d < NSRC) begin
            e_bus[s] = 1'b1;
            e_ld[d]  = 1'b1;
            e_busy   = 1'b1;
        end else begin
            e_err = 1'b1;
        end
        if (cont) begin
            m_cnt++;
        end else if (lock[win]) begin
            m_locked = 1'b1; m_lowner = win; m_cnt = 1;
        end else begin
            m_locked = 1'b0; m_cnt = 0;
        end
        m_ptr   = (win + 1) % NREQ;
        m_owner = win;
    endtask

    // Advance one clock with the current inputs and compare every output
    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        chk("gnt",      32'(gnt),      32'(e_gnt));
        chk("bus_ctrl", bus_ctrl,      e_bus);
        chk("ld_en",    ld_en,         e_ld);
        chk("busy",     32'(busy),     32'(e_busy));
        chk("err",      32'(err),      32'(e_err));
        chk("owner",    32'(owner),    32'(m_owner));
        chk("onehot",   32'(($countones(gnt) <= 1) && ($countones(bus_ctrl) <= 1)
                            && ($countones(ld_en) <= 1)), 32'd1);
    endtask

    task automatic do_reset();
        clear = 1'b1; req = 4'd0; lock = 4'd0;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int seq034 [6];
        int seq035 [6];
        tests_run = 0; tests_failed = 0;
        m_ptr = 0; m_locked = 1'b0; m_lowner = 0; m_cnt = 0; m_owner = 0;
        src_sel = 20'd0; dst_sel = 20'd0;
        seq034 = '{0, 1, 2, 3, 0, 1};
        seq035 = '{1, 1, 1, 1, 0, 1};

        // Reset state
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'd0);

        // Single PC -> MDR transfer from requester 0
        req = 4'b0001;
        src_sel[4:0] = 5'd20; dst_sel[4:0] = 5'd21;
        step();
        chk("t033_bus", bus_ctrl, 32'h0010_0000);
        chk("t033_ld",  ld_en,    32'h0020_0000);

        // Plain round-robin rotation
        do_reset();
        req = 4'b1111; lock = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src_sel[5*i +: 5] = 5'(i); dst_sel[5*i +: 5] = 5'(i + 4);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t034_seq", 32'(gnt), 32'(1) << seq034[i]);
        end

        // Locked burst limited to MAX_BURST grants
        do_reset();
        req = 4'b0001; lock = 4'b0000;
        step();
        req = 4'b0011; lock = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t035_seq", 32'(gnt), 32'(1) << seq035[i]);
        end

        // Out-of-range source still granted, flagged as error
        req = 4'b0100; lock = 4'b0000;
        src_sel[14:10] = 5'd25; dst_sel[14:10] = 5'd3;
        step();
        chk("t036_gnt", 32'(gnt), 32'h4);
        chk("t036_err", 32'(err), 32'd1);
        req = 4'b0000;
        step();

        // Clear in the middle of a burst
        do_reset();
        req = 4'b0010; lock = 4'b0010;
        src_sel[9:5] = 5'd2; dst_sel[9:5] = 5'd2;
        step();
        step();
        clear = 1'b1;
        step();
        chk("t037_clr", 32'(gnt), 32'd0);
        clear = 1'b0; req = 4'b1000; lock = 4'b0000;
        src_sel[19:15] = 5'd22; dst_sel[19:15] = 5'd0;
        step();
        chk("t037_gnt", 32'(gnt), 32'h8);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            clear = ($urandom_range(0, 199) == 0);
            req   = 4'($urandom());
            lock  = 4'($urandom()) & 4'($urandom());
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    src_sel[5*i +: 5] = 5'($urandom());
                    dst_sel[5*i +: 5] = 5'($urandom());
                end else begin
                    src_sel[5*i +: 5] = 5'($urandom_range(0, NSRC - 1));
                    dst_sel[5*i +: 5] = 5'($urandom_range(0, NSRC - 1));
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
